// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator. A clock divider produces one pixel
// tick every CLK_DIV enabled clk cycles. On each tick every output is loaded
// from the internal raster position and the position then advances, so the
// outputs always describe the pixel that was just issued. All outputs are
// registered, which keeps sync/DE/blank free of decode glitches.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   timing advance enable (freezes divider, position, outputs)
//   resync     in   synchronous restart to frame start (overrides en)
//   irq_line   in   line number compared against y for line_match
//   x, y       out  current pixel column / line
//   pix_ce     out  one-clk strobe: x/y/syncs were just updated
//   de         out  display enable (inside active area)
//   hblank     out  x >= H_ACTIVE
//   vblank     out  y >= V_ACTIVE
//   hsync      out  horizontal sync, active level H_POL
//   vsync      out  vertical sync, active level V_POL
//   newline    out  one-clk pulse with pix_ce when x = 0
//   newframe   out  one-clk pulse with pix_ce when x = 0, y = 0
//   line_match out  one-clk pulse with pix_ce when x = 0, y = irq_line
//   frame_cnt  out  completed-frame count (wraps, cleared only by rst_n)
// ----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               resync,
  input  logic [CW-1:0]      irq_line,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               pix_ce,
  output logic               de,
  output logic               hblank,
  output logic               vblank,
  output logic               hsync,
  output logic               vsync,
  output logic               newline,
  output logic               newframe,
  output logic               line_match,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider width; a 1-bit counter that never leaves 0 covers CLK_DIV = 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Raster landmarks, pre-sized to the counter width. Sync windows are
  // expressed as inclusive first/last so every bound fits in CW bits even
  // when the back porch is zero.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BLK_FST  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_BLK_FST  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FST     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LST     = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FST     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LST     = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] POS_ZERO   = {CW{1'b0}};

  localparam logic HSYNC_ON   = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VSYNC_ON   = (V_POL != 0) ? 1'b1 : 1'b0;
  localparam logic HSYNC_IDLE = ~HSYNC_ON;
  localparam logic VSYNC_IDLE = ~VSYNC_ON;

  // Divider and internal raster position (the pixel to be issued next).
  logic [DW-1:0]      div_q,   div_d;
  logic [CW-1:0]      pos_x_q, pos_x_d;
  logic [CW-1:0]      pos_y_q, pos_y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Registered outputs.
  logic [CW-1:0] x_q,      x_d;
  logic [CW-1:0] y_q,      y_d;
  logic          pix_ce_q, pix_ce_d;
  logic          de_q,     de_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          hsync_q,  hsync_d;
  logic          vsync_q,  vsync_d;
  logic          nline_q,  nline_d;
  logic          nframe_q, nframe_d;
  logic          lmatch_q, lmatch_d;

  // Combinational helpers.
  logic tick_s;
  logic at_eol_s;
  logic at_eof_s;
  logic at_x0_s;
  logic at_y0_s;
  logic hblank_s;
  logic vblank_s;
  logic hsync_act_s;
  logic vsync_act_s;

  // Pixel tick and position landmarks decoded from the internal position.
  always_comb begin
    tick_s      = en && (div_q == DIV_LAST);
    at_eol_s    = (pos_x_q == H_LAST);
    at_eof_s    = (pos_y_q == V_LAST);
    at_x0_s     = (pos_x_q == POS_ZERO);
    at_y0_s     = (pos_y_q == POS_ZERO);
    hblank_s    = (pos_x_q >= H_BLK_FST);
    vblank_s    = (pos_y_q >= V_BLK_FST);
    hsync_act_s = (pos_x_q >= HS_FST) && (pos_x_q <= HS_LST);
    vsync_act_s = (pos_y_q >= VS_FST) && (pos_y_q <= VS_LST);
  end

  // Divider next state: counts only while enabled, restarts on resync.
  always_comb begin
    div_d = div_q;
    if (resync) begin
      div_d = {DW{1'b0}};
    end else if (tick_s) begin
      div_d = {DW{1'b0}};
    end else if (en) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = div_q;
    end
  end

  // Raster position advance and completed-frame counting.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    frame_d = frame_q;
    if (resync) begin
      // Frame count deliberately survives a resync.
      pos_x_d = POS_ZERO;
      pos_y_d = POS_ZERO;
      frame_d = frame_q;
    end else if (tick_s) begin
      if (at_eol_s) begin
        pos_x_d = POS_ZERO;
        if (at_eof_s) begin
          pos_y_d = POS_ZERO;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          pos_y_d = pos_y_q + CW'(1);
          frame_d = frame_q;
        end
      end else begin
        pos_x_d = pos_x_q + CW'(1);
        pos_y_d = pos_y_q;
        frame_d = frame_q;
      end
    end else begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      frame_d = frame_q;
    end
  end

  // Output next state: load from the position on a tick, otherwise hold
  // levels and drop the single-cycle strobes.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    de_d     = de_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    pix_ce_d = 1'b0;
    nline_d  = 1'b0;
    nframe_d = 1'b0;
    lmatch_d = 1'b0;
    if (resync) begin
      x_d      = POS_ZERO;
      y_d      = POS_ZERO;
      de_d     = 1'b0;
      hblank_d = 1'b0;
      vblank_d = 1'b0;
      hsync_d  = HSYNC_IDLE;
      vsync_d  = VSYNC_IDLE;
    end else if (tick_s) begin
      x_d      = pos_x_q;
      y_d      = pos_y_q;
      hblank_d = hblank_s;
      vblank_d = vblank_s;
      de_d     = !hblank_s && !vblank_s;
      hsync_d  = hsync_act_s ? HSYNC_ON : HSYNC_IDLE;
      vsync_d  = vsync_act_s ? VSYNC_ON : VSYNC_IDLE;
      pix_ce_d = 1'b1;
      nline_d  = at_x0_s;
      nframe_d = at_x0_s && at_y0_s;
      // irq_line is sampled here, on the tick, so it may change freely.
      lmatch_d = at_x0_s && (pos_y_q == irq_line);
    end else begin
      x_d      = x_q;
      y_d      = y_q;
      de_d     = de_q;
      hblank_d = hblank_q;
      vblank_d = vblank_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= {DW{1'b0}};
      pos_x_q  <= POS_ZERO;
      pos_y_q  <= POS_ZERO;
      frame_q  <= {FRAME_W{1'b0}};
      x_q      <= POS_ZERO;
      y_q      <= POS_ZERO;
      pix_ce_q <= 1'b0;
      de_q     <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= HSYNC_IDLE;
      vsync_q  <= VSYNC_IDLE;
      nline_q  <= 1'b0;
      nframe_q <= 1'b0;
      lmatch_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      frame_q  <= frame_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_ce_q <= pix_ce_d;
      de_q     <= de_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      nline_q  <= nline_d;
      nframe_q <= nframe_d;
      lmatch_q <= lmatch_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign pix_ce     = pix_ce_q;
  assign de         = de_q;
  assign hblank     = hblank_q;
  assign vblank     = vblank_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign newline    = nline_q;
  assign newframe   = nframe_q;
  assign line_match = lmatch_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Three generator instances run side by side: default 640x480 timing, a tiny
// CLK_DIV=1 raster with active-high syncs, and a tiny CLK_DIV=3 raster with a
// 4-bit frame counter. A reference model per instance counts enabled clocks
// and issued pixels; every expected output is derived from the pixel index
// with plain arithmetic and compared every clock.
// ----------------------------------------------------------------------------
module tb_video_timing_gen;

  logic       clk;
  logic       rst_n;
  logic [2:0] en_v;
  logic [2:0] rs_v;
  logic [9:0] irq0;
  logic [3:0] irq1;
  logic [3:0] irq2;

  logic [9:0]  x0, y0;
  logic [3:0]  x1, y1, x2, y2;
  logic        pce0, de0, hb0, vb0, hs0, vs0, nl0, nf0, lm0;
  logic        pce1, de1, hb1, vb1, hs1, vs1, nl1, nf1, lm1;
  logic        pce2, de2, hb2, vb2, hs2, vs2, nl2, nf2, lm2;
  logic [15:0] fc0, fc1;
  logic [3:0]  fc2;

  video_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .resync(rs_v[0]), .irq_line(irq0),
    .x(x0), .y(y0), .pix_ce(pce0), .de(de0), .hblank(hb0), .vblank(vb0),
    .hsync(hs0), .vsync(vs0), .newline(nl0), .newframe(nf0),
    .line_match(lm0), .frame_cnt(fc0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .CW(4), .FRAME_W(16)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .resync(rs_v[1]), .irq_line(irq1),
    .x(x1), .y(y1), .pix_ce(pce1), .de(de1), .hblank(hb1), .vblank(vb1),
    .hsync(hs1), .vsync(vs1), .newline(nl1), .newframe(nf1),
    .line_match(lm1), .frame_cnt(fc1)
  );

  video_timing_gen #(
    .H_ACTIVE(5), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(3), .CW(4), .FRAME_W(4)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .resync(rs_v[2]), .irq_line(irq2),
    .x(x2), .y(y2), .pix_ce(pce2), .de(de2), .hblank(hb2), .vblank(vb2),
    .hsync(hs2), .vsync(vs2), .newline(nl2), .newframe(nf2),
    .line_match(lm2), .frame_cnt(fc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing description of each instance, as the reference model sees it.
  int m_ha[3]   = '{640, 8, 5};
  int m_hfp[3]  = '{16, 2, 2};
  int m_hsw[3]  = '{96, 3, 2};
  int m_hbp[3]  = '{48, 1, 3};
  int m_va[3]   = '{480, 4, 3};
  int m_vfp[3]  = '{10, 1, 1};
  int m_vsw[3]  = '{2, 1, 2};
  int m_vbp[3]  = '{33, 1, 1};
  int m_hpol[3] = '{0, 1, 0};
  int m_vpol[3] = '{0, 1, 0};
  int m_cdiv[3] = '{2, 1, 3};
  int m_fw[3]   = '{16, 16, 4};

  // Model state: enabled clocks since restart, index of last issued pixel
  // (-1 = none yet), frames counted before the last restart, strobes.
  int m_en_cnt[3];
  int m_k[3];
  int m_fb[3];
  bit m_pce[3];
  bit m_lm[3];

  int n_chk;
  int n_pass;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int htot(input int d);
    return m_ha[d] + m_hfp[d] + m_hsw[d] + m_hbp[d];
  endfunction

  function automatic int vtot(input int d);
    return m_va[d] + m_vfp[d] + m_vsw[d] + m_vbp[d];
  endfunction

  function automatic int exp_frame(input int d);
    if (m_k[d] < 0) return m_fb[d];
    return (m_fb[d] + (m_k[d] + 1) / (htot(d) * vtot(d))) % (1 << m_fw[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_en_cnt[d] = 0;
      m_k[d]      = -1;
      m_fb[d]     = 0;
      m_pce[d]    = 1'b0;
      m_lm[d]     = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit en, input bit rs, input int irq);
    int p;
    if (rs) begin
      m_fb[d]     = exp_frame(d);
      m_k[d]      = -1;
      m_en_cnt[d] = 0;
      m_pce[d]    = 1'b0;
      m_lm[d]     = 1'b0;
    end else if (en) begin
      m_en_cnt[d]++;
      if (m_en_cnt[d] % m_cdiv[d] == 0) begin
        m_k[d]++;
        p        = m_k[d] % (htot(d) * vtot(d));
        m_pce[d] = 1'b1;
        m_lm[d]  = (p % htot(d) == 0) && (p / htot(d) == irq);
      end else begin
        m_pce[d] = 1'b0;
        m_lm[d]  = 1'b0;
      end
    end else begin
      m_pce[d] = 1'b0;
      m_lm[d]  = 1'b0;
    end
  endtask

  task automatic check_dut(input int d, input string nm,
                           input logic [31:0] ox, input logic [31:0] oy,
                           input logic op, input logic ode, input logic ohb,
                           input logic ovb, input logic ohs, input logic ovs,
                           input logic onl, input logic onf, input logic olm,
                           input logic [31:0] ofc);
    int ex, ey, p;
    bit ehb, evb, ehs, evs;
    if (m_k[d] < 0) begin
      ex = 0; ey = 0; ehb = 1'b0; evb = 1'b0;
      ehs = (m_hpol[d] == 0); evs = (m_vpol[d] == 0);
    end else begin
      p   = m_k[d] % (htot(d) * vtot(d));
      ex  = p % htot(d);
      ey  = p / htot(d);
      ehb = ex >= m_ha[d];
      evb = ey >= m_va[d];
      ehs = ((ex >= m_ha[d] + m_hfp[d]) && (ex < m_ha[d] + m_hfp[d] + m_hsw[d]))
            ? (m_hpol[d] != 0) : (m_hpol[d] == 0);
      evs = ((ey >= m_va[d] + m_vfp[d]) && (ey < m_va[d] + m_vfp[d] + m_vsw[d]))
            ? (m_vpol[d] != 0) : (m_vpol[d] == 0);
    end
    check_val({nm, ".x"},          ox,  32'(ex));
    check_val({nm, ".y"},          oy,  32'(ey));
    check_val({nm, ".pix_ce"},     32'(op),  32'(m_pce[d]));
    check_val({nm, ".de"},         32'(ode), 32'((m_k[d] >= 0) && !ehb && !evb));
    check_val({nm, ".hblank"},     32'(ohb), 32'(ehb));
    check_val({nm, ".vblank"},     32'(ovb), 32'(evb));
    check_val({nm, ".hsync"},      32'(ohs), 32'(ehs));
    check_val({nm, ".vsync"},      32'(ovs), 32'(evs));
    check_val({nm, ".newline"},    32'(onl), 32'(m_pce[d] && ex == 0));
    check_val({nm, ".newframe"},   32'(onf), 32'(m_pce[d] && ex == 0 && ey == 0));
    check_val({nm, ".line_match"}, 32'(olm), 32'(m_lm[d]));
    check_val({nm, ".frame_cnt"},  ofc, 32'(exp_frame(d)));
  endtask

  task automatic check_all();
    check_dut(0, "d0", 32'(x0), 32'(y0), pce0, de0, hb0, vb0, hs0, vs0, nl0, nf0, lm0, 32'(fc0));
    check_dut(1, "d1", 32'(x1), 32'(y1), pce1, de1, hb1, vb1, hs1, vs1, nl1, nf1, lm1, 32'(fc1));
    check_dut(2, "d2", 32'(x2), 32'(y2), pce2, de2, hb2, vb2, hs2, vs2, nl2, nf2, lm2, 32'(fc2));
  endtask

  // One clock: advance the models with the inputs the DUTs saw on this
  // rising edge, then compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, en_v[0], rs_v[0], int'(irq0));
      model_step(1, en_v[1], rs_v[1], int'(irq1));
      model_step(2, en_v[2], rs_v[2], int'(irq2));
    end
    @(negedge clk);
    check_all();
  endtask

  // Random enable/resync/irq for the small instances, optionally instance 0.
  task automatic drive_rand(input bit ctl0);
    int irq_tab[5] = '{0, 1, 2, 3, 600};
    en_v[1] = ($urandom_range(0, 4) != 0);
    en_v[2] = ($urandom_range(0, 4) != 0);
    rs_v[1] = ($urandom_range(0, 1999) == 0);
    rs_v[2] = ($urandom_range(0, 2999) == 0);
    if ($urandom_range(0, 99) == 0) irq1 = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 99) == 0) irq2 = 4'($urandom_range(0, 15));
    if (ctl0) begin
      en_v[0] = ($urandom_range(0, 9) != 0);
      rs_v[0] = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 199) == 0) irq0 = 10'(irq_tab[$urandom_range(0, 4)]);
    end
  endtask

  initial begin
    int n;
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    en_v    = 3'b000;
    rs_v    = 3'b000;
    irq0    = 10'd3;
    irq1    = 4'd2;
    irq2    = 4'd1;
    model_reset();
    cycle();
    cycle();

    // Release reset with everything enabled; instance 0 issues (0,0) after
    // two enabled clocks.
    rst_n = 1'b1;
    en_v  = 3'b111;
    cycle();
    check_val("first_pce_early", 32'(pce0), 32'd0);
    cycle();
    check_val("first_pce", 32'(pce0), 32'd1);
    check_val("first_nf",  32'(nf0),  32'd1);
    check_val("first_de",  32'(de0),  32'd1);

    // Several lines on instance 0 (covers line wraps, hsync, line_match y=3).
    repeat (6000) begin
      drive_rand(1'b0);
      cycle();
    end

    // Freeze instance 0 for 7 clocks right after it issued x=100.
    n = 0;
    while (!(pce0 && x0 == 10'd100) && n < 4000) begin
      drive_rand(1'b0);
      cycle();
      n++;
    end
    check_val("wait_x100", 32'(pce0 && x0 == 10'd100), 32'd1);
    en_v[0] = 1'b0;
    repeat (7) begin
      drive_rand(1'b0);
      cycle();
    end
    en_v[0] = 1'b1;
    n = 0;
    while (!pce0 && n < 10) begin
      drive_rand(1'b0);
      cycle();
      n++;
    end
    check_val("resume_x101", 32'(x0), 32'd101);

    // Resync instance 0 right after x=300.
    n = 0;
    while (!(pce0 && x0 == 10'd300) && n < 4000) begin
      drive_rand(1'b0);
      cycle();
      n++;
    end
    check_val("wait_x300", 32'(pce0 && x0 == 10'd300), 32'd1);
    rs_v[0] = 1'b1;
    drive_rand(1'b0);
    cycle();
    rs_v[0] = 1'b0;

    // Everything randomised, including instance 0.
    repeat (3000) begin
      drive_rand(1'b1);
      cycle();
    end

    // Asynchronous reset in mid-line: outputs must clear before any edge.
    rs_v    = 3'b000;
    en_v    = 3'b111;
    repeat (5) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    cycle();
    rst_n = 1'b1;

    repeat (2000) begin
      drive_rand(1'b1);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
